// File: rtl/clkdiv_pkg.sv
// Shared types and helpers for the programmable clock divider.
// Optional odd-divisor 50% duty correction is enabled by ODD_DUTY50_EN.
package clkdiv_pkg;

    typedef enum logic {
        IDLE = 1'b0,
        RUN  = 1'b1
    } state_t;

    localparam int MIN_DIV     = 2;
    localparam int DEF_DIV_W   = 16;
    localparam int DEF_DIV_VAL = 64;

    // Divisors 0 and 1 would stall the counter; force them to the minimum.
    function automatic logic [31:0] clamp_div(input logic [31:0] v);
        return (v < 32'(MIN_DIV)) ? 32'(MIN_DIV) : v;
    endfunction

endpackage

// File: rtl/clkdiv_odd_stretch.sv
// Negedge duty stretcher: extends the high phase by half a cycle for odd N.
// Only instantiated when ODD_DUTY50_EN is defined.
module clkdiv_odd_stretch
    import clkdiv_pkg::*;
(
    input  logic clk_in,
    input  logic reset,
    input  logic i_clk_pos,
    input  logic i_odd,
    output logic o_clk
);

    logic r_neg;

    always_ff @(negedge clk_in or negedge reset) begin
        if (!reset) begin
            r_neg <= 1'b0;
        end else begin
            r_neg <= i_clk_pos;
        end
    end

    assign o_clk = i_clk_pos | (i_odd & r_neg);

endmodule

// File: rtl/prog_clk_divider.sv
// Run-time programmable integer clock divider with boundary-safe reload.
// Define ODD_DUTY50_EN for 50% duty on odd divisors (adds a negedge flop).
module prog_clk_divider
    import clkdiv_pkg::*;
#(
    parameter int DIV_W   = DEF_DIV_W,
    parameter int DEF_DIV = DEF_DIV_VAL
) (
    input  logic             clk_in,
    input  logic             reset,
    input  logic             enable,
    input  logic [DIV_W-1:0] div_val,
    input  logic             div_load,
    output logic             div_ack,
    output logic             clk_out,
    output logic             tick,
    output logic             busy
);

    state_t           r_state;
    logic [DIV_W-1:0] r_cnt;
    logic [DIV_W-1:0] r_n;
    logic [DIV_W-1:0] r_pend;
    logic             r_pend_vld;
    logic             r_clk;
    logic             r_tick;
    logic             r_ack;
    logic             r_busy;

    logic [DIV_W-1:0] w_clamped;
    logic [DIV_W-1:0] w_cnt_inc;
    logic [DIV_W-1:0] w_h;
    logic [DIV_W-1:0] w_new;
    logic             w_cap;
    logic             w_have;
    logic             w_wrap;

    assign w_clamped = DIV_W'(clamp_div(32'(div_val)));
    assign w_cnt_inc = r_cnt + 1'b1;
    assign w_h       = r_n >> 1;
    assign w_wrap    = (w_cnt_inc == r_n);
    assign w_cap     = div_load & ~r_ack;
    // A capture on the applying edge itself is the newest request.
    assign w_have    = r_pend_vld | w_cap;
    assign w_new     = w_cap ? w_clamped : r_pend;

    always_ff @(posedge clk_in or negedge reset) begin
        if (!reset) begin
            r_state    <= IDLE;
            r_cnt      <= '0;
            r_n        <= DIV_W'(DEF_DIV);
            r_pend     <= '0;
            r_pend_vld <= 1'b0;
            r_clk      <= 1'b0;
            r_tick     <= 1'b0;
            r_ack      <= 1'b0;
            r_busy     <= 1'b0;
        end else begin
            r_ack  <= 1'b0;
            r_tick <= 1'b0;
            if (w_cap) begin
                r_pend     <= w_clamped;
                r_pend_vld <= 1'b1;
            end
            unique case (r_state)
                IDLE: begin
                    r_cnt <= '0;
                    r_clk <= 1'b0;
                    if (w_have) begin
                        r_n        <= w_new;
                        r_ack      <= 1'b1;
                        r_pend_vld <= 1'b0;
                    end
                    if (enable) begin
                        r_state <= RUN;
                        r_busy  <= 1'b1;
                        r_clk   <= 1'b1;
                        r_tick  <= 1'b1;
                    end
                end
                RUN: begin
                    if (w_wrap) begin
                        r_cnt <= '0;
                        if (w_have) begin
                            r_n        <= w_new;
                            r_ack      <= 1'b1;
                            r_pend_vld <= 1'b0;
                        end
                        if (enable) begin
                            r_clk  <= 1'b1;
                            r_tick <= 1'b1;
                        end else begin
                            r_state <= IDLE;
                            r_clk   <= 1'b0;
                            r_busy  <= 1'b0;
                        end
                    end else begin
                        r_cnt <= w_cnt_inc;
                        r_clk <= (w_cnt_inc < w_h);
                    end
                end
            endcase
        end
    end

`ifdef ODD_DUTY50_EN
    logic w_clk_str;

    clkdiv_odd_stretch u_odd_stretch (
        .clk_in   (clk_in),
        .reset    (reset),
        .i_clk_pos(r_clk),
        .i_odd    (r_n[0]),
        .o_clk    (w_clk_str)
    );

    assign clk_out = w_clk_str;
`else
    assign clk_out = r_clk;
`endif

    assign div_ack = r_ack;
    assign tick    = r_tick;
    assign busy    = r_busy;

endmodule

// File: tb/tb_prog_clk_divider.sv
// Directed bench for prog_clk_divider: table of divisors plus corner sequences.
// Odd-N high-phase expectations follow ODD_DUTY50_EN when defined.
module tb_prog_clk_divider;

    localparam int DIV_W = 16;

    logic             clk_in;
    logic             reset;
    logic             enable;
    logic [DIV_W-1:0] div_val;
    logic             div_load;
    logic             div_ack;
    logic             clk_out;
    logic             tick;
    logic             busy;

    int checks;
    int failures;
    int ack_cnt;

    prog_clk_divider #(.DIV_W(DIV_W), .DEF_DIV(64)) dut (
        .clk_in  (clk_in),
        .reset   (reset),
        .enable  (enable),
        .div_val (div_val),
        .div_load(div_load),
        .div_ack (div_ack),
        .clk_out (clk_out),
        .tick    (tick),
        .busy    (busy)
    );

    initial clk_in = 1'b0;
    always #5 clk_in = ~clk_in;

    typedef struct {
        logic [DIV_W-1:0] val;
        int               per;
        int               hi;
        string            nm;
    } vec_t;

    vec_t vecs[6];

    task automatic check(input bit ok, input string nm, input int act, input int exp);
        checks++;
        if (!ok) begin
            failures++;
            $display("FAIL %s: got %0d expected %0d", nm, act, exp);
        end
    endtask

    // High samples per period as seen 1 ns after the rising edge.
    function automatic int adj_hi(input int hi, input int per);
`ifdef ODD_DUTY50_EN
        return hi + (per % 2);
`else
        return hi + 0 * per;
`endif
    endfunction

    task automatic step();
        @(posedge clk_in);
        #1;
        if (div_ack) ack_cnt++;
    endtask

    task automatic wait_tick(input string nm);
        int k;
        k = 0;
        do begin
            step();
            k++;
        end while (!tick && k < 300);
        if (!tick) check(1'b0, nm, k, 300);
    endtask

    task automatic wait_ack(input string nm);
        int k;
        k = 0;
        while (!div_ack && k < 300) begin
            step();
            k++;
        end
        check(div_ack, nm, int'(div_ack), 1);
    endtask

    // Starts on a tick sample, ends on the next tick sample.
    task automatic measure(input int hi_exp, input int per_exp, input string nm);
        int k;
        int hi;
        bit shape;
        k = 0;
        hi = 0;
        shape = 1'b1;
        do begin
            if (clk_out != (k < hi_exp)) shape = 1'b0;
            if (clk_out) hi++;
            step();
            k++;
        end while (!tick && k < 300);
        check(k == per_exp, {nm, " period"}, k, per_exp);
        check(hi == hi_exp, {nm, " high"}, hi, hi_exp);
        check(shape, {nm, " shape"}, int'(shape), 1);
    endtask

    task automatic load(input logic [DIV_W-1:0] v, input string nm);
        div_val  = v;
        div_load = 1'b1;
        wait_ack(nm);
        div_load = 1'b0;
    endtask

    initial begin
        int k;
        int hi;
        bit shape;
        checks   = 0;
        failures = 0;
        ack_cnt  = 0;

        vecs[0] = '{val: 16'd5,  per: 5,  hi: 2,  nm: "n5"};
        vecs[1] = '{val: 16'd0,  per: 2,  hi: 1,  nm: "n0_clamp"};
        vecs[2] = '{val: 16'd1,  per: 2,  hi: 1,  nm: "n1_clamp"};
        vecs[3] = '{val: 16'd3,  per: 3,  hi: 1,  nm: "n3"};
        vecs[4] = '{val: 16'd10, per: 10, hi: 5,  nm: "n10"};
        vecs[5] = '{val: 16'd64, per: 64, hi: 32, nm: "n64"};

        reset    = 1'b0;
        enable   = 1'b0;
        div_val  = '0;
        div_load = 1'b0;
        #2;
        check(clk_out == 1'b0, "rst clk_out", int'(clk_out), 0);
        check(tick == 1'b0, "rst tick", int'(tick), 0);
        check(div_ack == 1'b0, "rst div_ack", int'(div_ack), 0);
        check(busy == 1'b0, "rst busy", int'(busy), 0);
        repeat (3) step();

        // Default divisor after reset release.
        reset  = 1'b1;
        enable = 1'b1;
        check(clk_out == 1'b0, "pre-run clk_out", int'(clk_out), 0);
        step();
        check(clk_out == 1'b1, "start clk_out", int'(clk_out), 1);
        check(tick == 1'b1, "start tick", int'(tick), 1);
        check(busy == 1'b1, "start busy", int'(busy), 1);
        measure(32, 64, "def p1");
        measure(32, 64, "def p2");

        // Mid-period reload: transition period keeps the old shape.
        repeat (10) step();
        div_val  = 16'd5;
        div_load = 1'b1;
        k = 10;
        shape = 1'b1;
        while (!div_ack && k < 300) begin
            if (clk_out != (k < 32)) shape = 1'b0;
            step();
            k++;
        end
        div_load = 1'b0;
        check(k == 64, "mid ack edge", k, 64);
        check(tick == 1'b1, "mid ack tick", int'(tick), 1);
        check(shape, "mid no runt", int'(shape), 1);
        step();
        check(div_ack == 1'b0, "ack one pulse", int'(div_ack), 0);
        wait_tick("mid tick");
        measure(adj_hi(2, 5), 5, "mid n5");

        for (int i = 0; i < 6; i++) begin
            load(vecs[i].val, {vecs[i].nm, " ack"});
            wait_tick({vecs[i].nm, " tick"});
            measure(adj_hi(vecs[i].hi, vecs[i].per), vecs[i].per, {vecs[i].nm, " a"});
            measure(adj_hi(vecs[i].hi, vecs[i].per), vecs[i].per, {vecs[i].nm, " b"});
        end

        // Load raised on the boundary edge itself.
        repeat (63) step();
        div_val  = 16'd8;
        div_load = 1'b1;
        step();
        check(div_ack == 1'b1, "bnd ack", int'(div_ack), 1);
        check(tick == 1'b1, "bnd tick", int'(tick), 1);
        div_load = 1'b0;
        measure(4, 8, "bnd n8");

        // Back-to-back requests: last wins, single ack.
        ack_cnt = 0;
        step();
        div_val  = 16'd6;
        div_load = 1'b1;
        step();
        div_val = 16'd9;
        wait_ack("b2b ack");
        div_load = 1'b0;
        measure(adj_hi(4, 9), 9, "b2b n9");
        measure(adj_hi(4, 9), 9, "b2b n9 b");
        check(ack_cnt == 1, "b2b ack count", ack_cnt, 1);

        // Stop mid-period: finish the period, then idle low.
        load(16'd64, "stop ack");
        wait_tick("stop tick");
        repeat (3) step();
        enable = 1'b0;
        k = 3;
        shape = 1'b1;
        while (k < 63) begin
            if (clk_out != (k < 32)) shape = 1'b0;
            if (!busy) shape = 1'b0;
            step();
            k++;
        end
        check(shape, "stop finish period", int'(shape), 1);
        check(busy == 1'b1, "stop busy last", int'(busy), 1);
        step();
        check(busy == 1'b0, "stop busy", int'(busy), 0);
        check(clk_out == 1'b0, "stop clk_out", int'(clk_out), 0);
        hi = 0;
        repeat (10) begin
            step();
            if (clk_out || tick) hi++;
        end
        check(hi == 0, "idle quiet", hi, 0);
        enable = 1'b1;
        step();
        check(clk_out == 1'b1, "restart clk_out", int'(clk_out), 1);
        check(tick == 1'b1, "restart tick", int'(tick), 1);
        check(busy == 1'b1, "restart busy", int'(busy), 1);

        // Async reset on a high phase, with an ack in flight.
        load(16'd8, "rst ack");
        reset = 1'b0;
        #1;
        check(clk_out == 1'b0, "async clk_out", int'(clk_out), 0);
        check(tick == 1'b0, "async tick", int'(tick), 0);
        check(div_ack == 1'b0, "async div_ack", int'(div_ack), 0);
        check(busy == 1'b0, "async busy", int'(busy), 0);
        @(posedge clk_in);
        #1;
        reset = 1'b1;
        step();
        check(clk_out == 1'b1, "post-rst clk_out", int'(clk_out), 1);
        measure(32, 64, "post-rst n64");

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
